// File: rtl/u_rec_param.sv
// u_rec_param: parameterised UART receiver with a one-word holding register.
// A two-flop synchroniser feeds a bit-cell timed FSM (IDLE/START/DATA/
// [PARITY]/STOP/DONE). The completed word is offered on rec_dataH with
// valid/ack handshaking; a word finishing while the previous one is still
// held is dropped and flagged with a one-cycle rec_overrunH pulse.
// Optional feature macro: U_REC_PARITY_EN adds one parity bit per frame,
// the PARITY state and the rec_parErrH logic (PARITY_ODD selects the sense).
module u_rec_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 uart_dataH,
  input  logic                 rec_ackH,
  output logic [DATA_BITS-1:0] rec_dataH,
  output logic                 rec_validH,
  output logic                 rec_frameErrH,
  output logic                 rec_parErrH,
  output logic                 rec_overrunH
);

  localparam int CELL_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [CELL_W-1:0] CELL_LAST = CELL_W'(CLKS_PER_BIT - 1);
  localparam logic [CELL_W-1:0] CELL_HALF = CELL_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  // Refuse to elaborate with parameters outside their legal ranges.
  generate
    if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : gBadParam
      $error("u_rec_param: illegal parameter set");
    end
  endgenerate

`ifdef U_REC_PARITY_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4, DONE = 3'd5
  } recState;
  localparam logic ODD_SENSE = (PARITY_ODD != 0);
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4, DONE = 3'd5
  } recState;
`endif

  logic                 syncA, syncB;
  logic                 lineSync;
  recState              stateReg, stateNext;
  logic [CELL_W-1:0]    cellCnt, cellNext;
  logic [BIT_W-1:0]     bitCnt, bitNext;
  logic                 armedReg, armedNext;
  logic [DATA_BITS-1:0] shiftReg, shiftNext;
  logic                 frameErrPend, frameErrNext;
`ifdef U_REC_PARITY_EN
  logic                 parErrPend, parErrNext;
`endif

  assign lineSync = syncB;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      syncA <= 1'b1;
      syncB <= 1'b1;
    end else begin
      syncA <= uart_dataH;
      syncB <= syncA;
    end
  end

  // Frame FSM next-state, bit timing, shifting and error accumulation.
  always_comb begin
    stateNext    = stateReg;
    cellNext     = cellCnt + CELL_W'(1);
    bitNext      = bitCnt;
    armedNext    = armedReg;
    shiftNext    = shiftReg;
    frameErrNext = frameErrPend;
`ifdef U_REC_PARITY_EN
    parErrNext   = parErrPend;
`endif
    case (stateReg)
      IDLE: begin
        cellNext = '0;
        bitNext  = '0;
        // Arming needs a high line first, so a held break cannot retrigger.
        if (lineSync) begin
          armedNext = 1'b1;
        end else if (armedReg) begin
          armedNext    = 1'b0;
          frameErrNext = 1'b0;
`ifdef U_REC_PARITY_EN
          parErrNext   = 1'b0;
`endif
          stateNext    = START;
        end
      end
      START: begin
        // Mid-start-bit recheck rejects short glitches.
        if (cellCnt == CELL_HALF) stateNext = lineSync ? IDLE : DATA;
      end
      DATA: begin
        if (cellCnt == CELL_LAST) begin
          cellNext  = '0;
          shiftNext = {lineSync, shiftReg[DATA_BITS-1:1]};
          if (bitCnt == DATA_LAST) begin
            bitNext = '0;
`ifdef U_REC_PARITY_EN
            stateNext = PARITY;
`else
            stateNext = STOP;
`endif
          end else begin
            bitNext = bitCnt + BIT_W'(1);
          end
        end
      end
`ifdef U_REC_PARITY_EN
      PARITY: begin
        if (cellCnt == CELL_LAST) begin
          parErrNext = (^shiftReg) ^ lineSync ^ ODD_SENSE;
          stateNext  = STOP;
        end
      end
`endif
      STOP: begin
        if (cellCnt == CELL_LAST) begin
          cellNext = '0;
          if (!lineSync) frameErrNext = 1'b1;
          if (bitCnt == STOP_LAST) begin
            bitNext   = '0;
            stateNext = DONE;
          end else begin
            bitNext = bitCnt + BIT_W'(1);
          end
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (stateNext != stateReg) cellNext = '0;
  end

  // FSM and datapath registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stateReg     <= IDLE;
      cellCnt      <= '0;
      bitCnt       <= '0;
      armedReg     <= 1'b0;
      shiftReg     <= '0;
      frameErrPend <= 1'b0;
`ifdef U_REC_PARITY_EN
      parErrPend   <= 1'b0;
`endif
    end else begin
      stateReg     <= stateNext;
      cellCnt      <= cellNext;
      bitCnt       <= bitNext;
      armedReg     <= armedNext;
      shiftReg     <= shiftNext;
      frameErrPend <= frameErrNext;
`ifdef U_REC_PARITY_EN
      parErrPend   <= parErrNext;
`endif
    end
  end

  // Holding register: load in DONE when free or being acked, else drop and flag overrun.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rec_dataH     <= '0;
      rec_validH    <= 1'b0;
      rec_frameErrH <= 1'b0;
      rec_overrunH  <= 1'b0;
`ifdef U_REC_PARITY_EN
      rec_parErrH   <= 1'b0;
`endif
    end else begin
      rec_overrunH <= 1'b0;
      if (stateReg == DONE) begin
        if (!rec_validH || rec_ackH) begin
          rec_dataH     <= shiftReg;
          rec_frameErrH <= frameErrPend;
`ifdef U_REC_PARITY_EN
          rec_parErrH   <= parErrPend;
`endif
          rec_validH    <= 1'b1;
        end else begin
          rec_overrunH <= 1'b1;
        end
      end else if (rec_validH && rec_ackH) begin
        rec_validH <= 1'b0;
      end
    end
  end

`ifndef U_REC_PARITY_EN
  assign rec_parErrH = 1'b0;
`endif

endmodule

// File: tb/tb_u_rec_param.sv
// tb_u_rec_param: randomized, self-checking bench for u_rec_param.
// Instance dut uses one stop bit, dut2 two stop bits; both DATA_BITS=8,
// CLKS_PER_BIT=16. Frames are built bit by bit from the data word, and the
// expected word, error flags and valid-rise cycle come from the frame itself.
`timescale 1ns/1ps
module tb_u_rec_param;
  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int ODD = 0;
`ifdef U_REC_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic rst1, rst2, line1, line2, ack1, ack2;
  logic [7:0] data1, data2;
  logic valid1, fe1, pe1, ov1, valid2, fe2, pe2, ov2;

  u_rec_param #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(ODD)) dut (
    .sys_clk(sys_clk), .sys_rst(rst1), .uart_dataH(line1), .rec_ackH(ack1),
    .rec_dataH(data1), .rec_validH(valid1), .rec_frameErrH(fe1), .rec_parErrH(pe1),
    .rec_overrunH(ov1));

  u_rec_param #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(ODD)) dut2 (
    .sys_clk(sys_clk), .sys_rst(rst2), .uart_dataH(line2), .rec_ackH(ack2),
    .rec_dataH(data2), .rec_validH(valid2), .rec_frameErrH(fe2), .rec_parErrH(pe2),
    .rec_overrunH(ov2));

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [7:0] data; logic fe; logic pe; } rec_t;
  rec_t q1[$];
  rec_t q2[$];
  int ovCnt1 = 0, ovCnt2 = 0, hiCnt1 = 0, lastOvCyc1 = -1;
  logic prevV1 = 1'b0, prevV2 = 1'b0;
  int nCmp = 0, nBad = 0;

  // Observe each DUT: record every delivered word with the cycle valid rose.
  always @(negedge sys_clk) begin
    if (valid1 && !prevV1) q1.push_back('{cyc, data1, fe1, pe1});
    if (valid2 && !prevV2) q2.push_back('{cyc, data2, fe2, pe2});
    prevV1 <= valid1;
    prevV2 <= valid2;
    if (valid1) hiCnt1 <= hiCnt1 + 1;
    if (ov1) begin
      ovCnt1 <= ovCnt1 + 1;
      lastOvCyc1 <= cyc;
    end
    if (ov2) ovCnt2 <= ovCnt2 + 1;
  end

  // Expected valid-rise cycle for a start bit driven just after edge k:
  // 2 synchroniser + 1 detect cycles, half a bit to the start recheck,
  // one bit time per remaining bit, then DONE and the output register.
  function automatic int expRise(input int k, input int nStop);
    return k + 4 + CPB / 2 + (DB + PAR + nStop) * CPB;
  endfunction

  function automatic logic goodPar(input logic [7:0] d);
    return (($countones(d) % 2) == 1) ^ (ODD == 1);
  endfunction

  function automatic logic expPe(input logic [7:0] d, input logic p);
    if (PAR == 0) return 1'b0;
    return ((($countones(d) + int'(p)) % 2) != ODD);
  endfunction

  task automatic setLine(input int sel, input logic b);
    if (sel == 1) line1 = b; else line2 = b;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic holdBit(input int sel, input logic b, input logic doRst);
    setLine(sel, b);
    for (int c = 0; c < CPB; c++) begin
      if (doRst) begin
        if (sel == 1) rst1 = (c == 3); else rst2 = (c == 3);
      end
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic sendFrame(input int sel, input logic [7:0] d, input logic parBit,
                           input logic [1:0] stops, input int nStop, input int rstBit,
                           output int k);
    @(posedge sys_clk);
    #1;
    k = cyc;
    holdBit(sel, 1'b0, 1'b0);
    for (int i = 0; i < DB; i++) holdBit(sel, d[i], (i == rstBit));
    if (PAR == 1) holdBit(sel, parBit, 1'b0);
    for (int s = 0; s < nStop; s++) holdBit(sel, stops[s], 1'b0);
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst2 = 1'b1;
    idle(3);
    nCmp++; if (valid1 !== 1'b0) begin nBad++; $display("FAIL reset_valid: got %b want 0", valid1); end
    nCmp++; if (data1 !== 8'h00) begin nBad++; $display("FAIL reset_data: got %h want 00", data1); end
    nCmp++; if (fe1 !== 1'b0) begin nBad++; $display("FAIL reset_fe: got %b want 0", fe1); end
    nCmp++; if (pe1 !== 1'b0) begin nBad++; $display("FAIL reset_pe: got %b want 0", pe1); end
    nCmp++; if (ov1 !== 1'b0) begin nBad++; $display("FAIL reset_ov: got %b want 0", ov1); end
    nCmp++; if (valid2 !== 1'b0) begin nBad++; $display("FAIL reset_valid2: got %b want 0", valid2); end
    rst1 = 1'b0; rst2 = 1'b0;
    idle(4);
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int k, n0, h0;
    rec_t r;
    ack1 = 1'b1;
    n0 = q1.size(); h0 = hiCnt1;
    sendFrame(1, 8'hA5, goodPar(8'hA5), 2'b11, 1, -1, k);
    idle(3);
    nCmp++;
    if (q1.size() != n0 + 1) begin
      nBad++; $display("FAIL basic_count: got %0d want %0d", q1.size() - n0, 1);
    end else begin
      r = q1[$];
      nCmp++; if (r.data !== 8'hA5) begin nBad++; $display("FAIL basic_data: got %h want a5", r.data); end
      nCmp++; if (r.fe !== 1'b0) begin nBad++; $display("FAIL basic_fe: got %b want 0", r.fe); end
      nCmp++; if (r.pe !== 1'b0) begin nBad++; $display("FAIL basic_pe: got %b want 0", r.pe); end
      nCmp++; if (r.cyc != expRise(k, 1)) begin nBad++; $display("FAIL basic_latency: got %0d want %0d", r.cyc, expRise(k, 1)); end
    end
    nCmp++; if (hiCnt1 - h0 != 1) begin nBad++; $display("FAIL basic_valid_width: got %0d want 1", hiCnt1 - h0); end
    $display("test_basic frame a5 done");
  endtask

  task automatic test_random();
    int k, n0;
    logic [7:0] d;
    logic p;
    logic [1:0] st;
    rec_t r;
    ack1 = 1'b1;
    for (int t = 0; t < 12; t++) begin
      d = 8'($urandom);
      p = 1'($urandom);
      st = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
      n0 = q1.size();
      sendFrame(1, d, p, st, 1, -1, k);
      setLine(1, 1'b1);
      idle($urandom_range(2, 6));
      nCmp++;
      if (q1.size() != n0 + 1) begin
        nBad++; $display("FAIL rand_count[%0d]: got %0d want 1", t, q1.size() - n0);
      end else begin
        r = q1[$];
        nCmp++; if (r.data !== d) begin nBad++; $display("FAIL rand_data[%0d]: got %h want %h", t, r.data, d); end
        nCmp++; if (r.fe !== ~st[0]) begin nBad++; $display("FAIL rand_fe[%0d]: got %b want %b", t, r.fe, ~st[0]); end
        nCmp++; if (r.pe !== expPe(d, p)) begin nBad++; $display("FAIL rand_pe[%0d]: got %b want %b", t, r.pe, expPe(d, p)); end
        nCmp++; if (r.cyc != expRise(k, 1)) begin nBad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", t, r.cyc, expRise(k, 1)); end
      end
      $display("test_random frame %0d data %h stop %b", t, d, st[0]);
    end
  endtask

  task automatic test_glitch();
    int k, n0;
    n0 = q1.size();
    setLine(1, 1'b0);
    idle(5);
    setLine(1, 1'b1);
    idle(40);
    nCmp++; if (q1.size() != n0) begin nBad++; $display("FAIL glitch_no_word: got %0d want 0", q1.size() - n0); end
    sendFrame(1, 8'h3C, goodPar(8'h3C), 2'b11, 1, -1, k);
    idle(3);
    nCmp++;
    if (q1.size() != n0 + 1) begin
      nBad++; $display("FAIL glitch_next_count: got %0d want 1", q1.size() - n0);
    end else begin
      nCmp++; if (q1[$].data !== 8'h3C) begin nBad++; $display("FAIL glitch_next_data: got %h want 3c", q1[$].data); end
    end
    $display("test_glitch done");
  endtask

  task automatic test_break();
    int k, n0;
    n0 = q1.size();
    sendFrame(1, 8'h3C, goodPar(8'h3C), 2'b00, 1, -1, k);
    idle(40);
    nCmp++;
    if (q1.size() != n0 + 1) begin
      nBad++; $display("FAIL break_count: got %0d want 1", q1.size() - n0);
    end else begin
      nCmp++; if (q1[$].data !== 8'h3C) begin nBad++; $display("FAIL break_data: got %h want 3c", q1[$].data); end
      nCmp++; if (q1[$].fe !== 1'b1) begin nBad++; $display("FAIL break_fe: got %b want 1", q1[$].fe); end
      nCmp++; if (q1[$].cyc != expRise(k, 1)) begin nBad++; $display("FAIL break_latency: got %0d want %0d", q1[$].cyc, expRise(k, 1)); end
    end
    setLine(1, 1'b1);
    idle(4);
    n0 = q1.size();
    sendFrame(1, 8'h96, goodPar(8'h96), 2'b11, 1, -1, k);
    idle(3);
    nCmp++;
    if (q1.size() != n0 + 1) begin
      nBad++; $display("FAIL break_after_count: got %0d want 1", q1.size() - n0);
    end else begin
      nCmp++; if (q1[$].data !== 8'h96 || q1[$].fe !== 1'b0) begin
        nBad++; $display("FAIL break_after_word: got %h/%b want 96/0", q1[$].data, q1[$].fe);
      end
    end
    $display("test_break done");
  endtask

  task automatic test_overrun();
    int k, k2, n0, o0;
    ack1 = 1'b0;
    n0 = q1.size(); o0 = ovCnt1;
    sendFrame(1, 8'h11, goodPar(8'h11), 2'b11, 1, -1, k);
    idle(3);
    sendFrame(1, 8'h22, goodPar(8'h22), 2'b11, 1, -1, k2);
    idle(3);
    nCmp++; if (q1.size() != n0 + 1) begin nBad++; $display("FAIL ovr_count: got %0d want 1", q1.size() - n0); end
    nCmp++; if (data1 !== 8'h11) begin nBad++; $display("FAIL ovr_data_kept: got %h want 11", data1); end
    nCmp++; if (valid1 !== 1'b1) begin nBad++; $display("FAIL ovr_valid: got %b want 1", valid1); end
    nCmp++; if (ovCnt1 - o0 != 1) begin nBad++; $display("FAIL ovr_pulses: got %0d want 1", ovCnt1 - o0); end
    nCmp++; if (lastOvCyc1 != expRise(k2, 1)) begin nBad++; $display("FAIL ovr_pulse_cycle: got %0d want %0d", lastOvCyc1, expRise(k2, 1)); end
    ack1 = 1'b1;
    idle(1);
    nCmp++; if (valid1 !== 1'b0) begin nBad++; $display("FAIL ovr_ack_clear: got %b want 0", valid1); end
    nCmp++; if (data1 !== 8'h11) begin nBad++; $display("FAIL ovr_ack_data_hold: got %h want 11", data1); end
    $display("test_overrun done");
  endtask

`ifdef U_REC_PARITY_EN
  task automatic test_parity();
    int k, n0;
    ack1 = 1'b1;
    for (int t = 0; t < 2; t++) begin
      n0 = q1.size();
      sendFrame(1, 8'h07, t[0], 2'b11, 1, -1, k);
      idle(3);
      nCmp++;
      if (q1.size() != n0 + 1) begin
        nBad++; $display("FAIL par_count[%0d]: got %0d want 1", t, q1.size() - n0);
      end else begin
        nCmp++; if (q1[$].data !== 8'h07) begin nBad++; $display("FAIL par_data[%0d]: got %h want 07", t, q1[$].data); end
        nCmp++; if (q1[$].pe !== (t == 0)) begin nBad++; $display("FAIL par_err[%0d]: got %b want %b", t, q1[$].pe, (t == 0)); end
      end
      $display("test_parity parity bit %0d done", t);
    end
  endtask
`endif

  task automatic test_two_stop();
    int k, n0;
    logic [7:0] d;
    logic [1:0] st;
    ack2 = 1'b1;
    for (int t = 0; t < 6; t++) begin
      d = 8'($urandom);
      st = 2'(t % 4);
      n0 = q2.size();
      sendFrame(2, d, goodPar(d), st, 2, -1, k);
      setLine(2, 1'b1);
      idle(3);
      nCmp++;
      if (q2.size() != n0 + 1) begin
        nBad++; $display("FAIL two_stop_count[%0d]: got %0d want 1", t, q2.size() - n0);
      end else begin
        nCmp++; if (q2[$].data !== d) begin nBad++; $display("FAIL two_stop_data[%0d]: got %h want %h", t, q2[$].data, d); end
        nCmp++; if (q2[$].fe !== (st != 2'b11)) begin nBad++; $display("FAIL two_stop_fe[%0d]: got %b want %b", t, q2[$].fe, (st != 2'b11)); end
        nCmp++; if (q2[$].cyc != expRise(k, 2)) begin nBad++; $display("FAIL two_stop_latency[%0d]: got %0d want %0d", t, q2[$].cyc, expRise(k, 2)); end
      end
      $display("test_two_stop frame %0d data %h stops %b", t, d, st);
    end
  endtask

  task automatic test_reset_midframe();
    int k, n0, o0;
    // Park a word in dut2 so the reset has something visible to clear.
    ack2 = 1'b0;
    sendFrame(2, 8'hC3, goodPar(8'hC3), 2'b11, 2, -1, k);
    setLine(2, 1'b1);
    idle(3);
    nCmp++; if (valid2 !== 1'b1 || data2 !== 8'hC3) begin nBad++; $display("FAIL rstmid_parked: got %b/%h want 1/c3", valid2, data2); end
    n0 = q2.size(); o0 = ovCnt2;
    sendFrame(2, 8'h5A, goodPar(8'h5A), 2'b11, 2, 3, k);
    setLine(2, 1'b1);
    nCmp++; if (valid2 !== 1'b0) begin nBad++; $display("FAIL rstmid_valid: got %b want 0", valid2); end
    nCmp++; if (data2 !== 8'h00) begin nBad++; $display("FAIL rstmid_data: got %h want 00", data2); end
    nCmp++; if (fe2 !== 1'b0 || pe2 !== 1'b0) begin nBad++; $display("FAIL rstmid_flags: got %b%b want 00", fe2, pe2); end
    nCmp++; if (q2.size() != n0 || ovCnt2 != o0) begin nBad++; $display("FAIL rstmid_no_word: got %0d words %0d overruns want 0 0", q2.size() - n0, ovCnt2 - o0); end
    // Later bits of the abandoned frame can look like a fresh start bit;
    // let any such word finish and be consumed before the clean frame.
    ack2 = 1'b1;
    idle(16 * CPB);
    n0 = q2.size();
    sendFrame(2, 8'h5A, goodPar(8'h5A), 2'b11, 2, -1, k);
    idle(3);
    nCmp++;
    if (q2.size() != n0 + 1) begin
      nBad++; $display("FAIL rstmid_next_count: got %0d want 1", q2.size() - n0);
    end else begin
      nCmp++; if (q2[$].data !== 8'h5A) begin nBad++; $display("FAIL rstmid_next_data: got %h want 5a", q2[$].data); end
      nCmp++; if (q2[$].fe !== 1'b0) begin nBad++; $display("FAIL rstmid_next_fe: got %b want 0", q2[$].fe); end
      nCmp++; if (q2[$].cyc != expRise(k, 2)) begin nBad++; $display("FAIL rstmid_next_latency: got %0d want %0d", q2[$].cyc, expRise(k, 2)); end
    end
    $display("test_reset_midframe done");
  endtask

  initial begin
    line1 = 1'b1; line2 = 1'b1;
    ack1 = 1'b1; ack2 = 1'b1;
    rst1 = 1'b1; rst2 = 1'b1;
    test_reset();
    test_basic();
    test_random();
    test_glitch();
    test_break();
    test_overrun();
`ifdef U_REC_PARITY_EN
    test_parity();
`endif
    test_two_stop();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/u_rec_param.md
U_REC_PARAM -- requirements
Module: u_rec_param

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, sys_clk cycles per bit, even and >= 4.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame, legal values 1 or 2.
REQ-004 SHALL have parameter PARITY_ODD, default 0, where 0 = even and 1 = odd (used only under U_REC_PARITY_EN).
REQ-005 SHALL have port sys_clk, input, 1 bit, single clock; all logic on its rising edge.
REQ-006 SHALL have port sys_rst, input, 1 bit, reset; synchronous, active-high.
REQ-007 SHALL have port uart_dataH, input, 1 bit, asynchronous serial line, idle high.
REQ-008 SHALL have port rec_ackH, input, 1 bit, consumer accepts the held word.
REQ-009 SHALL have port rec_dataH, output, DATA_BITS bits, received word, LSB first on the line.
REQ-010 SHALL have port rec_validH, output, 1 bit, rec_dataH holds an unconsumed word.
REQ-011 SHALL have port rec_frameErrH, output, 1 bit, status qualified by rec_validH; set when any stop bit sampled low.
REQ-012 SHALL have port rec_parErrH, output, 1 bit, parity mismatch, qualified by rec_validH.
REQ-013 SHALL have port rec_overrunH, output, 1 bit, one-cycle pulse when a completed word is dropped.

Function
REQ-014 SHALL pass uart_dataH through a two-flop synchroniser; every sample below uses the synchronised bit.
REQ-015 SHALL implement the states IDLE, START, DATA, PARITY, STOP and DONE, with one bit-cell counter and one bit counter.
- Bit-cell counter: clears on every state change and on every sample.
REQ-016 IDLE: SHALL set an internal armed flag when the line is high; when armed and the line is low, clear armed and go to START.
REQ-017 START: at count CLKS_PER_BIT/2-1, SHALL go to DATA if the line is low, else return to IDLE (glitch rejection).
REQ-018 DATA: at count CLKS_PER_BIT-1, SHALL sample the line, shift it in LSB first and increment the bit counter.
- After DATA_BITS samples, go to PARITY if parity is compiled in, else to STOP.
REQ-019 PARITY: at count CLKS_PER_BIT-1, SHALL sample the parity bit and compute the mismatch against the PARITY_ODD sense; then go to STOP.
REQ-020 STOP: at count CLKS_PER_BIT-1, SHALL sample each of the STOP_BITS stop bits; any low sample sets a pending frame error.
- After the last stop bit, go to DONE.
REQ-021 DONE: SHALL last one cycle and then return to IDLE.
- The armed flag is still clear, so a line held low (break) starts no new frame until it returns high.
REQ-022 Latency: rec_validH SHALL rise exactly 2 sys_clk cycles after the cycle in which the last stop bit is sampled.
REQ-023 In DONE with holding register free (rec_validH=0), or rec_validH=1 and rec_ackH=1 the same cycle:
- SHALL load rec_dataH, rec_frameErrH and rec_parErrH, and set rec_validH=1.
REQ-024 In DONE with rec_validH=1 and rec_ackH=0:
- SHALL keep the old word and flags, drop the new word, and pulse rec_overrunH for one cycle.
REQ-025 rec_ackH while rec_validH=1 outside DONE SHALL clear rec_validH next cycle; rec_dataH and the flags hold their values.
- rec_ackH while rec_validH=0 SHALL be ignored.
REQ-026 Counters SHALL be sized by $clog2 of their limits; no wrap SHALL occur in legal operation, and an illegal state code SHALL return to IDLE.

Reset
REQ-027 While sys_rst=1 at a clock edge, the block SHALL set:
- state = IDLE, both counters = 0, armed = 0, synchroniser flops = 1.
- rec_dataH = 0, and rec_validH, rec_frameErrH, rec_parErrH, rec_overrunH = 0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no output pulse; the first complete frame after release SHALL be received normally.

Configuration
REQ-029 With macro U_REC_PARITY_EN defined, the PARITY state and rec_parErrH logic SHALL be present, and frames carry one parity bit after the data.
REQ-030 Without U_REC_PARITY_EN, the PARITY state SHALL be absent, frames carry no parity bit, and rec_parErrH SHALL be tied 0.

Verification (DATA_BITS=8, CLKS_PER_BIT=16, STOP_BITS=1 unless stated)
REQ-031 Frame 0xA5 with rec_ackH held 1 -> rec_dataH=0xA5, rec_validH high for 1 cycle, both error flags 0, rec_validH rising 2 cycles after the stop sample.
REQ-032 Line low for 5 cycles, then high -> no rec_validH, FSM back in IDLE, next frame 0x3C received as 0x3C.
REQ-033 Frame 0x3C with stop bit low, line held low for 40 cycles -> rec_dataH=0x3C, rec_frameErrH=1, no second frame until the line returns high.
REQ-034 Frames 0x11 then 0x22 with rec_ackH=0 -> rec_dataH stays 0x11, one rec_overrunH pulse at the second DONE.
- Then assert rec_ackH -> rec_validH=0 next cycle.
REQ-035 U_REC_PARITY_EN defined, PARITY_ODD=0, frame 0x07 with parity bit 0 -> rec_dataH=0x07, rec_parErrH=1.
- Same frame with parity bit 1 -> rec_parErrH=0.
REQ-036 STOP_BITS=2, frame 0x5A, sys_rst pulsed 1 cycle during data bit 3 -> all outputs 0, no rec_validH.
- Following full frame 0x5A with both stop bits high -> rec_dataH=0x5A, rec_frameErrH=0.
